// File: rtl/adder_pipe_wrapper.sv
// Two-stage elastic valid/ready wrapper around a 32-bit carry-bypass adder.
// Define ADDER_PIPE_SATURATE_EN to clamp overflowing sums to the signed limits.

module carry_bypass_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] p;
    logic [8:0]  c_blk;
    logic        rc;

    assign p = a ^ b;

    // 4-bit ripple blocks; a fully propagating block forwards its carry-in.
    always_comb begin
        sum      = '0;
        c_blk    = '0;
        rc       = 1'b0;
        c_blk[0] = cin;
        for (int k = 0; k < 8; k++) begin
            rc = c_blk[k];
            for (int j = 0; j < 4; j++) begin
                sum[4*k+j] = p[4*k+j] ^ rc;
                rc = (a[4*k+j] & b[4*k+j]) | (rc & p[4*k+j]);
            end
            c_blk[k+1] = (&p[4*k +: 4]) ? c_blk[k] : rc;
        end
        cout = c_blk[8];
    end

endmodule

module adder_pipe_wrapper #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_sum,
    output logic             out_cout,
    output logic             out_overflow,
    output logic [CNT_W-1:0] ovf_count
);

    logic        s1_valid;
    logic        s2_valid;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic        s1_cin;
    logic        s2_free;
    logic        s1_adv;
    logic        accept;
    logic        deliver;
    logic [31:0] raw_sum;
    logic        raw_cout;
    logic        raw_ovf;
    logic [31:0] next_sum;

    assign s2_free   = ~s2_valid | out_ready;
    assign s1_adv    = s1_valid & s2_free;
    assign in_ready  = ~s1_valid | s1_adv;
    assign accept    = in_valid & in_ready;
    assign out_valid = s2_valid;
    assign deliver   = s2_valid & out_ready;

    carry_bypass_adder u_add (
        .a    (s1_a),
        .b    (s1_b),
        .cin  (s1_cin),
        .sum  (raw_sum),
        .cout (raw_cout)
    );

    assign raw_ovf = (s1_a[31] & s1_b[31] & ~raw_sum[31])
                   | (~s1_a[31] & ~s1_b[31] & raw_sum[31]);

`ifdef ADDER_PIPE_SATURATE_EN
    always_comb begin
        next_sum = raw_sum;
        if (raw_ovf)
            next_sum = s1_a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`else
    assign next_sum = raw_sum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_cin   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_cin   <= in_cin;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid     <= 1'b0;
            out_sum      <= '0;
            out_cout     <= 1'b0;
            out_overflow <= 1'b0;
        end else if (s1_adv) begin
            s2_valid     <= 1'b1;
            out_sum      <= next_sum;
            out_cout     <= raw_cout;
            out_overflow <= raw_ovf;
        end else if (deliver) begin
            s2_valid     <= 1'b0;
        end
    end

    // Counts delivered overflows only; sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst)
            ovf_count <= '0;
        else if (deliver && out_overflow && ovf_count != '1)
            ovf_count <= ovf_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_adder_pipe_wrapper.sv
// Self-checking bench for adder_pipe_wrapper: directed vectors, stall,
// reset flush, random streaming against a queue model, counter saturation.

module tb_adder_pipe_wrapper;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_sum;
    logic        out_cout;
    logic        out_overflow;
    logic [15:0] ovf_count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic [31:0] s_in_a;
    logic [31:0] s_in_b;
    logic        s_in_cin;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [31:0] s_out_sum;
    logic        s_out_cout;
    logic        s_out_overflow;
    logic [1:0]  s_ovf_count;

    always #5 clk = ~clk;

    adder_pipe_wrapper #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout),
        .out_overflow(out_overflow), .ovf_count(ovf_count)
    );

    adder_pipe_wrapper #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_a(s_in_a), .in_b(s_in_b), .in_cin(s_in_cin),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_sum(s_out_sum), .out_cout(s_out_cout),
        .out_overflow(s_out_overflow), .ovf_count(s_ovf_count)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;
    logic [33:0] expq[$];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {sum, cout, ovf} from plain wide arithmetic
    function automatic logic [33:0] model(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic c);
        logic [32:0] full;
        logic [31:0] s;
        logic        v;
        full = {1'b0, a} + {1'b0, b} + {32'd0, c};
        v = (a[31] == b[31]) && (full[31] != a[31]);
        s = full[31:0];
`ifdef ADDER_PIPE_SATURATE_EN
        if (v) s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return {s, full[32], v};
    endfunction

    // Entered just after a negedge with inputs set; leaves after next negedge.
    task automatic cycle(output bit acc, output bit dlv);
        logic [33:0] e;
        bit          stall;
        logic [33:0] held;
        #1;
        acc   = in_valid && in_ready;
        dlv   = out_valid && out_ready;
        stall = out_valid && !out_ready;
        held  = {out_sum, out_cout, out_overflow};
        if (dlv) begin
            if (expq.size() == 0) begin
                chk("unexpected_delivery", 1, 0);
            end else begin
                e = expq.pop_front();
                chk("stream_result", {out_sum, out_cout, out_overflow}, e);
                if (e[0] && exp_cnt < 65535) exp_cnt++;
            end
        end
        if (acc) expq.push_back(model(in_a, in_b, in_cin));
        @(posedge clk);
        @(negedge clk);
        if (stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_hold", {out_sum, out_cout, out_overflow}, held);
        end
        chk("ovf_count", ovf_count, exp_cnt);
    endtask

    task automatic stream(input int n, input int rdy_pct, output int cycles);
        int sent;
        bit acc;
        bit dlv;
        sent = 0;
        cycles = 0;
        in_valid = 1'b0;
        while (sent < n || expq.size() != 0) begin
            if (!in_valid && sent < n) begin
                in_a = $urandom;
                in_b = $urandom;
                in_cin = 1'($urandom_range(1));
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            cycle(acc, dlv);
            cycles++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            if (cycles > 20 * n + 50) begin
                chk("stream_timeout", 1, 0);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic single(input vec_t v, input int idx);
        in_a = v.a;
        in_b = v.b;
        in_cin = v.cin;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1 chk($sformatf("vec%0d_in_ready", idx), in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("vec%0d_early", idx), out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d_valid", idx), out_valid, 1);
        chk($sformatf("vec%0d_sum", idx), out_sum, v.sum);
        chk($sformatf("vec%0d_cout", idx), out_cout, v.cout);
        chk($sformatf("vec%0d_ovf", idx), out_overflow, v.ovf);
        if (v.ovf) exp_cnt++;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("vec%0d_drained", idx), out_valid, 0);
        chk($sformatf("vec%0d_count", idx), ovf_count, exp_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[9];
        bit   acc;
        bit   dlv;
        int   cyc;
        int   nd;

`ifdef ADDER_PIPE_SATURATE_EN
        vt[2] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1};
        vt[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 1'b1, 1'b1};
        vt[5] = '{32'h7FFF_FFFF, 32'h0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1};
`else
        vt[2] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vt[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1};
        vt[5] = '{32'h7FFF_FFFF, 32'h0, 1'b1, 32'h8000_0000, 1'b0, 1'b1};
`endif
        vt[0] = '{32'h5, 32'h3, 1'b1, 32'h9, 1'b0, 1'b0};
        vt[1] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0};
        vt[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
        vt[6] = '{32'h1234_5678, 32'h0FED_CBA9, 1'b0, 32'h2222_2221, 1'b0, 1'b0};
        vt[7] = '{32'h0000_FFFF, 32'h1, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
        vt[8] = '{32'hFFFF_0000, 32'h0000_FFFF, 1'b1, 32'h0, 1'b1, 1'b0};

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        s_in_valid = 1'b0; s_in_a = '0; s_in_b = '0; s_in_cin = 1'b0;
        s_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_outputs", {out_sum, out_cout, out_overflow}, 0);
        chk("rst_ovf_count", ovf_count, 0);
        @(negedge clk);

        foreach (vt[i]) single(vt[i], i);

        // Backpressure: two accepts fill the pipe, third waits upstream.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_cin = 1'b0;
        cycle(acc, dlv);
        chk("bp_acc0", acc, 1);
        in_a = 32'h7FFF_0000; in_b = 32'h0001_0000; in_cin = 1'b1;
        cycle(acc, dlv);
        chk("bp_acc1", acc, 1);
        in_a = 32'hDEAD_BEEF; in_b = 32'h0BAD_F00D; in_cin = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1 chk("bp_in_ready_low", in_ready, 0);
            cycle(acc, dlv);
            chk("bp_no_accept", acc, 0);
        end
        out_ready = 1'b1;
        nd = 0;
        for (int k = 0; k < 10 && (in_valid || expq.size() != 0); k++) begin
            cycle(acc, dlv);
            if (acc) in_valid = 1'b0;
            if (dlv) nd++;
        end
        chk("bp_delivered", nd, 3);
        chk("bp_queue_empty", expq.size(), 0);

        // Full-rate streaming: 100 results in 100 + 2 cycles.
        stream(100, 100, cyc);
        chk("tput_cycles", cyc, 102);
        stream(60, 50, cyc);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 32'h7FFF_FFFF; in_b = 32'h7FFF_FFFF; in_cin = 1'b0;
        cycle(acc, dlv);
        cycle(acc, dlv);
        in_valid = 1'b0;
        #1;
        chk("pre_rst_full", {out_valid, in_ready}, 2'b10);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        exp_cnt = 0;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", out_sum, 0);
        chk("mid_rst_count", ovf_count, 0);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle(acc, dlv);
            chk("no_stale", dlv, 0);
        end
        stream(20, 70, cyc);

        // Saturation with a 2-bit counter.
        chk("sat_start", s_ovf_count, 0);
        s_out_ready = 1'b1;
        s_in_valid = 1'b1;
        s_in_a = 32'h7FFF_FFFF; s_in_b = 32'h1; s_in_cin = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5) s_in_valid = 1'b0;
            if (k >= 3)
                chk($sformatf("sat_count%0d", k - 2), s_ovf_count,
                    (k - 2 < 3) ? k - 2 : 3);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
